// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-file hazard scoreboard.
// Register 0 is hardwired and never tracked; register 31 is the JAL link register.
package scoreboard_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int REG_ZERO = 0;
    localparam int REG_LINK = 31;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/flush bundle between the pipeline and the scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface reg_scoreboard_if;
    import scoreboard_pkg::*;

    logic                IssueValid;
    logic [ADDR_W-1:0]   IssueRs;
    logic [ADDR_W-1:0]   IssueRt;
    logic                IssueUsesRs;
    logic                IssueUsesRt;
    logic                IssueWrEn;
    logic [ADDR_W-1:0]   IssueRd;
    logic                RetireValid;
    logic [ADDR_W-1:0]   RetireRd;
    logic                Flush;
    logic                Stall;
    logic [NUM_REGS-1:0] BusyMask;
    logic                RetireErr;

    modport master (
        output IssueValid, IssueRs, IssueRt, IssueUsesRs, IssueUsesRt,
        output IssueWrEn, IssueRd, RetireValid, RetireRd, Flush,
        input  Stall, BusyMask, RetireErr
    );

    modport slave (
        input  IssueValid, IssueRs, IssueRt, IssueUsesRs, IssueUsesRt,
        input  IssueWrEn, IssueRd, RetireValid, RetireRd, Flush,
        output Stall, BusyMask, RetireErr
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// Simultaneous inc and dec cancel; clr wins over both.
module sb_counter
    import scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic busy,
    output logic full,
    output logic single,
    output logic underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign busy      = (cnt != '0);
    assign full      = (cnt == CNT_MAX);
    assign single    = (cnt == CNT_ONE);
    // A net-zero inc/dec pair is a legal same-cycle issue+retire, not an underflow.
    assign underflow = dec && !inc && !clr && (cnt == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Read-side hazard scoreboard: per-register pending-write counters and issue stall.
// Define SCOREBOARD_BYPASS_EN to let a source retiring this cycle count as ready.
module reg_scoreboard
    import scoreboard_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    reg_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] busyVec;
    logic [NUM_REGS-1:0] fullVec;
    logic [NUM_REGS-1:0] singleVec;
    logic [NUM_REGS-1:0] underVec;
    logic                rsBusy;
    logic                rtBusy;
    logic                stall;
    logic                acceptWr;
    logic                retireErr;

    assign busyVec[REG_ZERO]   = 1'b0;
    assign fullVec[REG_ZERO]   = 1'b0;
    assign singleVec[REG_ZERO] = 1'b0;
    assign underVec[REG_ZERO]  = 1'b0;

    for (genvar i = REG_ZERO + 1; i <= REG_LINK; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk       (Clk),
            .rst       (Reset),
            .inc       (acceptWr && sb.IssueRd == ADDR_W'(i)),
            .dec       (sb.RetireValid && sb.RetireRd == ADDR_W'(i)),
            .clr       (sb.Flush),
            .busy      (busyVec[i]),
            .full      (fullVec[i]),
            .single    (singleVec[i]),
            .underflow (underVec[i])
        );
    end

`ifdef SCOREBOARD_BYPASS_EN
    // Last outstanding writer retiring now: the register file forwards it write-first.
    always_comb begin
        rsBusy = sb.IssueUsesRs && busyVec[sb.IssueRs] &&
                 !(sb.RetireValid && sb.RetireRd == sb.IssueRs && singleVec[sb.IssueRs]);
        rtBusy = sb.IssueUsesRt && busyVec[sb.IssueRt] &&
                 !(sb.RetireValid && sb.RetireRd == sb.IssueRt && singleVec[sb.IssueRt]);
    end
`else
    logic unusedSingle;
    assign unusedSingle = ^singleVec;

    always_comb begin
        rsBusy = sb.IssueUsesRs && busyVec[sb.IssueRs];
        rtBusy = sb.IssueUsesRt && busyVec[sb.IssueRt];
    end
`endif

    always_comb begin
        stall = sb.IssueValid &&
                (rsBusy || rtBusy ||
                 (sb.IssueWrEn && sb.IssueRd != ADDR_W'(REG_ZERO) && fullVec[sb.IssueRd]));
        acceptWr = sb.IssueValid && !stall && sb.IssueWrEn &&
                   sb.IssueRd != ADDR_W'(REG_ZERO);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retireErr <= 1'b0;
        end else if (|underVec) begin
            retireErr <= 1'b1;
        end
    end

    assign sb.Stall     = stall;
    assign sb.BusyMask  = busyVec;
    assign sb.RetireErr = retireErr;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver queues expected Stall/BusyMask/RetireErr
// per cycle and an independent monitor pops and compares them on the falling edge.
module tb_reg_scoreboard;
    import scoreboard_pkg::*;

    typedef struct {
        int          cyc;
        int          kind;   // 0 Stall, 1 BusyMask, 2 RetireErr
        string       name;
        logic [31:0] value;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatch = 0;
    exp_t q[$];

    reg_scoreboard_if sbIf ();

    reg_scoreboard dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sb    (sbIf.slave)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic idleInputs();
        sbIf.IssueValid  = 1'b0;
        sbIf.IssueRs     = '0;
        sbIf.IssueRt     = '0;
        sbIf.IssueUsesRs = 1'b0;
        sbIf.IssueUsesRt = 1'b0;
        sbIf.IssueWrEn   = 1'b0;
        sbIf.IssueRd     = '0;
        sbIf.RetireValid = 1'b0;
        sbIf.RetireRd    = '0;
        sbIf.Flush       = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
        idleInputs();
        Reset = 1'b0;
    endtask

    task automatic pushExp(input int kind, input string name, input logic [31:0] value);
        exp_t e;
        e.cyc   = cyc;
        e.kind  = kind;
        e.name  = name;
        e.value = value;
        q.push_back(e);
    endtask

    task automatic issue(input int rs, input logic usesRs, input int rt, input logic usesRt,
                         input logic wrEn, input int rd);
        sbIf.IssueValid  = 1'b1;
        sbIf.IssueRs     = ADDR_W'(rs);
        sbIf.IssueUsesRs = usesRs;
        sbIf.IssueRt     = ADDR_W'(rt);
        sbIf.IssueUsesRt = usesRt;
        sbIf.IssueWrEn   = wrEn;
        sbIf.IssueRd     = ADDR_W'(rd);
    endtask

    task automatic retire(input int rd);
        sbIf.RetireValid = 1'b1;
        sbIf.RetireRd    = ADDR_W'(rd);
    endtask

    // Monitor: compare every expectation tagged with the current cycle.
    always @(negedge Clk) begin
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            case (e.kind)
                0:       act = {31'b0, sbIf.Stall};
                1:       act = sbIf.BusyMask;
                default: act = {31'b0, sbIf.RetireErr};
            endcase
            nCompared++;
            if (e.cyc != cyc) begin
                nMismatch++;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                         e.name, e.cyc, cyc);
            end else if (act !== e.value) begin
                nMismatch++;
                $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                         e.name, cyc, act, e.value);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idleInputs();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;

        // Reset state
        nextCycle();
        pushExp(0, "reset_stall", 0);
        pushExp(1, "reset_mask", 0);
        pushExp(2, "reset_err", 0);

        // lw $8 then dependent add on $8
        nextCycle();
        issue(29, 1, 0, 0, 1, 8);
        pushExp(0, "lw_issue_stall", 0);
        nextCycle();
        issue(8, 1, 9, 1, 1, 10);
        pushExp(0, "raw_stall_a", 1);
        pushExp(1, "lw_busy8", 32'd1 << 8);
        nextCycle();
        issue(8, 1, 9, 1, 1, 10);
        retire(8);
`ifdef SCOREBOARD_BYPASS_EN
        pushExp(0, "raw_retire_cycle_stall", 0);
`else
        pushExp(0, "raw_retire_cycle_stall", 1);
`endif
        nextCycle();
`ifdef SCOREBOARD_BYPASS_EN
        pushExp(1, "after_retire8_mask", 32'd1 << 10);
`else
        issue(8, 1, 9, 1, 1, 10);
        pushExp(0, "raw_after_retire_stall", 0);
        pushExp(1, "after_retire8_mask", 0);
`endif
        nextCycle();
        retire(10);
        pushExp(1, "add_busy10", 32'd1 << 10);
        nextCycle();
        pushExp(1, "drain10_mask", 0);

        // Writes and reads of $0 are ignored
        nextCycle();
        issue(0, 1, 0, 1, 1, 0);
        pushExp(0, "zero_stall", 0);
        nextCycle();
        pushExp(1, "zero_mask", 0);

        // Three writers to $9 saturate its counter
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            issue(0, 0, 0, 0, 1, 9);
            pushExp(0, "fill9_stall", 0);
        end
        nextCycle();
        issue(0, 0, 0, 0, 1, 9);
        pushExp(0, "full9_stall", 1);
        pushExp(1, "full9_mask", 32'd1 << 9);
        nextCycle();
        issue(0, 0, 0, 0, 1, 9);
        retire(9);
        pushExp(0, "full9_retire_cycle_stall", 1);
        nextCycle();
        issue(0, 0, 0, 0, 1, 9);
        pushExp(0, "fourth9_accept_stall", 0);
        nextCycle();
        issue(0, 0, 0, 0, 1, 9);
        retire(9);
        pushExp(0, "refull9_stall", 1);
        nextCycle();
        retire(9);
        nextCycle();
        retire(9);
        pushExp(1, "drain9_partial_mask", 32'd1 << 9);
        nextCycle();
        pushExp(1, "drain9_mask", 0);
        pushExp(2, "drain9_err", 0);

        // Same-cycle issue and retire of $5 leaves the count unchanged
        nextCycle();
        issue(0, 0, 0, 0, 1, 5);
        nextCycle();
        issue(0, 0, 0, 0, 1, 5);
        retire(5);
        pushExp(0, "iss_ret5_stall", 0);
        nextCycle();
        retire(5);
        pushExp(1, "iss_ret5_mask", 32'd1 << 5);
        pushExp(2, "iss_ret5_err", 0);
        nextCycle();
        pushExp(1, "drain5_mask", 0);

        // JAL to $31, flush (also dropping a concurrent issue), then stray retire
        nextCycle();
        issue(0, 0, 0, 0, 1, REG_LINK);
        nextCycle();
        issue(0, 0, 0, 0, 1, 6);
        sbIf.Flush = 1'b1;
        pushExp(1, "jal_mask", 32'd1 << 31);
        nextCycle();
        retire(REG_LINK);
        pushExp(1, "flush_mask", 0);
        pushExp(2, "flush_err", 0);
        nextCycle();
        sbIf.Flush = 1'b1;
        pushExp(2, "stray31_err", 1);
        pushExp(1, "stray31_mask", 0);
        nextCycle();
        pushExp(2, "err_after_flush", 1);
        Reset = 1'b1;

        // Reset clears the sticky error; then retire $12 with nothing pending
        nextCycle();
        retire(12);
        pushExp(2, "err_after_reset", 0);
        pushExp(1, "mask_after_reset", 0);
        nextCycle();
        pushExp(2, "retire12_err", 1);
        pushExp(1, "retire12_mask", 0);

        nextCycle();
        nextCycle();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nCompared++;
            nMismatch++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
